fp_min_reduce: RTL
==================

// Module: fp_min_reduce
// PURPOSE
//  Streaming min-reduction stage built around the combinational fp_min datapath.
//  Accepts a packet of FP operands (valid/ready, in_last marks the final element).
//  Folds each element into a running accumulator through fp_min.
//  Emits one result per packet with sticky status flags and an element count.
//  Sits downstream of operand sources and upstream of result writeback.
// PARAMETERS
//  SIGN_W  1   sign field width
//  EXPO_W  8   exponent field width
//  MANT_W  23  mantissa field width; FP_W = SIGN_W+EXPO_W+MANT_W
//  CNT_W   8   element-counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      input element valid
//  in_ready    out  1      block can accept an element
//  in_data     in   FP_W   FP operand
//  in_last     in   1      element is the last of its packet
//  rnd         in   2      rounding mode; sampled with the first element of a packet
//  out_valid   out  1      reduced result available
//  out_ready   in   1      consumer accepts the result
//  out_data    out  FP_W   minimum of the packet, as produced by fp_min
//  out_status  out  5      bitwise OR of the fp_min status over all folds in the packet
//  out_count   out  CNT_W  number of elements in the packet (saturating)
// BEHAVIOUR
//  Reset, on posedge clk while rst=1:
//   - state=IDLE; out_valid=0; out_data=0; out_status=0; out_count=0.
//   - Internal accumulator, rnd register and counter are cleared.
//   - in_ready=0 while rst=1.
//   - Reset mid-packet discards the partial packet; no result is emitted.
//  Accept rule:
//   - An element transfers when in_valid & in_ready.
//   - Output transfers when out_valid & out_ready.
//  FSM, 3 states:
//   IDLE (in_ready=1):
//    - On accept, load acc=in_data, rnd_q=rnd, status=0, count=1.
//    - If in_last, go to DONE; otherwise go to ACC.
//    - A first element is loaded unchanged and is not passed through fp_min.
//   ACC (in_ready=1):
//    - On accept, acc <= fp_min(acc, in_data, rnd_q).res.
//    - status |= fp_min.status; count += 1, saturating at all-ones.
//    - If in_last, go to DONE.
//    - Cycles with no accept hold all state.
//   DONE (in_ready=0, out_valid=1):
//    - out_data/out_status/out_count are stable and driven from registers.
//    - On out_ready, go to IDLE; out_valid=0 the next cycle.
//    - Backpressure is unbounded and outputs are held.
//  Latency:
//   - out_valid rises the cycle after the in_last element is accepted.
//   - Minimum packet-to-packet spacing is 1 bubble cycle (the DONE->IDLE handoff).
//  fp_min is instantiated once and is combinational: acc and in_data go into
//   ina and inb respectively. There is no extra pipeline register inside the fold.
//  rnd changes mid-packet are ignored; rnd_q holds for the whole packet.
//  NaN, zero-sign and flag semantics are exactly those of fp_min; this block adds none.
//  in_data, in_last and rnd are don't-care when in_valid=0.
//  out_* are don't-care when out_valid=0, but they hold their last values.
// TESTING (FP32 defaults)
//  1. Packet {3F800000, C0400000, 40000000 last}, out_ready=1:
//     out_data=C0400000, out_count=3, out_status=0.
//     out_valid is high exactly 1 cycle, which is the cycle after the last accept.
//  2. Single element {40000000 last}:
//     out_data=40000000, out_count=1, out_status=0.
//     in_ready=0 while out_valid=1.
//  3. Packet {3F800000, 7F800001 (sNaN) last}:
//     out_data and out_status equal fp_min(3F800000, 7F800001) for the same rnd.
//     The invalid flag is asserted.
//  4. out_ready=0 for 10 cycles after DONE:
//     outputs are held constant, in_ready stays 0, and no input is consumed.
//     Raising out_ready gives 1 transfer, and in_ready=1 the following cycle.
//  5. rst=1 asserted after 2 of 4 elements:
//     the next cycle all outputs are 0 and state is IDLE.
//     A fresh packet {BF800000 last} yields out_data=BF800000, out_count=1.
//  6. CNT_W=2, packet of 6 elements {min at element 6 = FF800000}:
//     out_count=3 (saturated), out_data=FF800000.
//     Includes in_valid gaps between elements.

Source files
------------

// File: rtl/fp_min_reduce.sv
// rtl/fp_min_reduce.sv - streaming min-reduction of FP packets around a combinational fp_min datapath
// Holds the fp_min datapath and the packet fold FSM that drives it.

module fp_min #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] ina_i,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] inb_i,
    input  logic [1:0]                      rnd_i,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] res_o,
    output logic [4:0]                      status_o
);
    localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
    localparam int MAG_W = EXPO_W + MANT_W;

    logic              a_sign, b_sign;
    logic [MAG_W-1:0]  a_mag, b_mag;
    logic              a_nan, b_nan, a_snan, b_snan;
    logic              a_lt_b;
    logic [FP_W-1:0]   qnan;
    // Min never rounds; the mode is carried only to keep the datapath interface uniform.
    logic              unused_rnd;

    assign unused_rnd = ^rnd_i;

    assign a_sign = ina_i[FP_W-1];
    assign b_sign = inb_i[FP_W-1];
    assign a_mag  = ina_i[MAG_W-1:0];
    assign b_mag  = inb_i[MAG_W-1:0];

    assign a_nan  = (&ina_i[MANT_W +: EXPO_W]) && (|ina_i[MANT_W-1:0]);
    assign b_nan  = (&inb_i[MANT_W +: EXPO_W]) && (|inb_i[MANT_W-1:0]);
    assign a_snan = a_nan && !ina_i[MANT_W-1];
    assign b_snan = b_nan && !inb_i[MANT_W-1];

    // -0 orders below +0 because differing signs resolve purely on the sign bit.
    always_comb begin
        a_lt_b = 1'b0;
        if (a_sign != b_sign) begin
            a_lt_b = a_sign;
        end else if (a_sign) begin
            a_lt_b = (a_mag > b_mag);
        end else begin
            a_lt_b = (a_mag < b_mag);
        end
    end

    always_comb begin
        qnan                    = '0;
        qnan[MANT_W +: EXPO_W]  = '1;
        qnan[MANT_W-1]          = 1'b1;
    end

    always_comb begin
        res_o    = inb_i;
        status_o = '0;
        status_o[4] = a_snan | b_snan;
        if (a_nan && b_nan) begin
            res_o = qnan;
        end else if (a_nan) begin
            res_o = inb_i;
        end else if (b_nan) begin
            res_o = ina_i;
        end else if (a_lt_b) begin
            res_o = ina_i;
        end else begin
            res_o = inb_i;
        end
    end
endmodule

module fp_min_reduce #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_data,
    input  logic                            in_last,
    input  logic [1:0]                      rnd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_data,
    output logic [4:0]                      out_status,
    output logic [CNT_W-1:0]                out_count
);
    localparam int FP_W = SIGN_W + EXPO_W + MANT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FP_W-1:0]   acc_q, acc_d;
    logic [1:0]        rnd_q, rnd_d;
    logic [4:0]        status_q, status_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FP_W-1:0]   min_res;
    logic [4:0]        min_status;
    logic              accept;

    fp_min #(
        .SIGN_W (SIGN_W),
        .EXPO_W (EXPO_W),
        .MANT_W (MANT_W)
    ) u_fp_min (
        .ina_i    (acc_q),
        .inb_i    (in_data),
        .rnd_i    (rnd_q),
        .res_o    (min_res),
        .status_o (min_status)
    );

    assign in_ready   = !rst && (state_q != ST_DONE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_data   = acc_q;
    assign out_status = status_q;
    assign out_count  = count_q;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rnd_d    = rnd_q;
        status_d = status_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                // The first element seeds the accumulator without a fold.
                if (accept) begin
                    acc_d    = in_data;
                    rnd_d    = rnd;
                    status_d = '0;
                    count_d  = CNT_W'(1);
                    state_d  = in_last ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d    = min_res;
                    status_d = status_q | min_status;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            rnd_q    <= '0;
            status_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rnd_q    <= rnd_d;
            status_q <= status_d;
            count_q  <= count_d;
        end
    end
endmodule
